counter_load_sequencer: RTL
===========================

COUNTER_LOAD_SEQUENCER -- requirements
Module: counter_load_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4, clk cycles per cen period (legal 2..16).
REQ-002 SHALL have ports in this order:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_start  in  8  preset value.
- cmd_len  in  8  number of count steps.
- cmd_dir  in  1  1 = up, 0 = down.
- cen  out  1  counter clock-enable pulse.
- direction  out  1  counter direction.
- load_n  out  1  counter load, active low.
- ent_n  out  1  counter enable T, active low.
- enp_n  out  1  counter enable P, active low.
- P  out  8  counter preset data.
- q_in  in  8  counter Q returned.
- busy  out  1  command in progress.
- done  out  1  one-clk completion pulse.
- mismatch  out  1  sticky check failure.
REQ-003 SHALL register every output.

Function
REQ-004 SHALL run a free prescaler 0..DIV-1; cen SHALL be high for exactly one clk when the prescaler wraps, first pulse DIV clks after Reset deasserts.
REQ-005 SHALL implement FSM IDLE, LOAD, COUNT, DONE.
REQ-006 IDLE: cmd_ready=1, busy=0, load_n=ent_n=enp_n=1; on cmd_valid&cmd_ready SHALL latch start/len/dir, drive P=cmd_start, direction=cmd_dir, go LOAD next clk.
REQ-007 LOAD: load_n=0 SHALL be held until one cen pulse has been issued with load_n=0; next clk: len=0 -> DONE, else COUNT.
REQ-008 COUNT: load_n=1, ent_n=enp_n=0; remaining SHALL decrement on each cen pulse; after the pulse that takes remaining to 0, go DONE.
REQ-009 Control outputs SHALL change only in the clk after a cen pulse or in IDLE, never in the cen-high clk nor the clk before it.
REQ-010 DONE: ent_n=enp_n=1, load_n=1, done=1 for one clk, then IDLE; cmd_ready=0 in LOAD, COUNT, DONE.
REQ-011 Expected value SHALL be start after load, then +1 (up) or -1 (down) per count pulse, 8-bit modulo wrap (255->0 up, 0->255 down).
REQ-012 cmd_valid while busy SHALL be ignored (not latched).
REQ-013 busy SHALL be 1 from the clk after acceptance through the DONE clk.

Reset
REQ-014 Reset high SHALL force, on the next clk: IDLE, prescaler=0, cen=0, load_n=ent_n=enp_n=1, direction=1, P=0, busy=0, done=0, mismatch=0, cmd_ready=1.
REQ-015 Reset mid-LOAD or mid-COUNT SHALL abort without done pulse; no further cen until DIV clks after release.

Configuration
REQ-016 Macro CNT_SEQ_CHECK_EN defined: q_in SHALL be compared to expected value 2 clks after each cen pulse in LOAD/COUNT; inequality sets mismatch, cleared on next command acceptance or Reset.
REQ-017 Macro undefined: no comparator or expected-value register; mismatch tied 0; q_in unused.

Verification (DIV=4, behavioural 8-bit loadable up/down counter attached)
REQ-018 start=0x10, len=3, dir=1 -> exactly 1 load pulse + 3 count pulses, final q_in=0x13, done once, mismatch=0.
REQ-019 start=0xFE, len=3, dir=1 -> q_in sequence 0xFE,0xFF,0x00,0x01; mismatch=0.
REQ-020 start=0x01, len=2, dir=0 -> q_in 0x01,0x00,0xFF; done pulse; busy low the clk after done.
REQ-021 len=0, start=0x55 -> load only, ent_n never low, q_in=0x55, done pulse.
REQ-022 Reset asserted during COUNT step 2 of len=5 -> next clk IDLE, all outputs per REQ-014, no done pulse; new command then runs normally.
REQ-023 With CNT_SEQ_CHECK_EN, counter forced to hold (ent tied high) on start=0x20, len=2 -> mismatch=1 after first count pulse, stays 1 until next accept.

Source files
------------

// File: rtl/counter_load_sequencer.sv
// counter_load_sequencer
//
// Drives an external 8-bit loadable up/down counter (74x169 style control
// pins) through one load step followed by a programmable number of count
// steps. A free-running prescaler produces the counter clock-enable (cen);
// every control pin only moves in the clk right after a cen pulse, so the
// counter always sees stable controls around its enabled edge.
//
// Parameter
//   DIV        clk cycles per cen period, legal 2..16
//
// Ports
//   clk        system clock, rising edge
//   Reset      synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command accepted when high together with cmd_valid
//   cmd_start  preset value
//   cmd_len    number of count steps
//   cmd_dir    1 = up, 0 = down
//   cen        counter clock-enable pulse (one clk wide)
//   direction  counter direction
//   load_n     counter load, active low
//   ent_n      counter enable T, active low
//   enp_n      counter enable P, active low
//   P          counter preset data
//   q_in       counter Q returned
//   busy       command in progress
//   done       one-clk completion pulse
//   mismatch   sticky readback check failure
//
// Build option
//   CNT_SEQ_CHECK_EN  when defined, q_in is compared with the expected
//                     counter value two clks after every load/count cen
//                     pulse; without it mismatch stays 0 and q_in is unused.
module counter_load_sequencer #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_start,
   input  logic [7:0] cmd_len,
   input  logic       cmd_dir,
   output logic       cen,
   output logic       direction,
   output logic       load_n,
   output logic       ent_n,
   output logic       enp_n,
   output logic [7:0] P,
   input  logic [7:0] q_in,
   output logic       busy,
   output logic       done,
   output logic       mismatch
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_r;
   logic [PW-1:0] presc_r;
   logic [7:0]    remaining_r;
   logic          accept_s;

   // cmd_ready is a register, so acceptance is a clean AND of two flops
   assign accept_s = cmd_valid & cmd_ready;

   // Free-running prescaler; cen is registered so it rises with the wrap
   always_ff @(posedge clk) begin
      if (Reset) begin
         presc_r <= '0;
         cen     <= 1'b0;
      end else begin
         if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
         end else begin
            presc_r <= presc_r + PW'(1);
         end
         cen <= (presc_r == PRESC_LAST);
      end
   end

   // Sequencer FSM; all control outputs are updated here as registers
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_r     <= S_IDLE;
         remaining_r <= 8'd0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_n      <= 1'b1;
         ent_n       <= 1'b1;
         enp_n       <= 1'b1;
         direction   <= 1'b1;
         P           <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  P           <= cmd_start;
                  direction   <= cmd_dir;
                  remaining_r <= cmd_len;
                  load_n      <= 1'b0;
                  cmd_ready   <= 1'b0;
                  busy        <= 1'b1;
                  state_r     <= S_LOAD;
               end
            end
            S_LOAD: begin
               // load_n is already low here, so any cen seen in LOAD is
               // the load pulse; leave on the clk after it
               if (cen) begin
                  load_n <= 1'b1;
                  if (remaining_r == 8'd0) begin
                     done    <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     ent_n   <= 1'b0;
                     enp_n   <= 1'b0;
                     state_r <= S_COUNT;
                  end
               end
            end
            S_COUNT: begin
               if (cen) begin
                  remaining_r <= remaining_r - 8'd1;
                  if (remaining_r == 8'd1) begin
                     ent_n   <= 1'b1;
                     enp_n   <= 1'b1;
                     done    <= 1'b1;
                     state_r <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state_r   <= S_IDLE;
            end
            default: begin
               load_n    <= 1'b1;
               ent_n     <= 1'b1;
               enp_n     <= 1'b1;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CNT_SEQ_CHECK_EN
   logic [7:0] expect_r;
   logic       chk1_r;
   logic       chk2_r;

   // Expected counter value plus a two-clk delay line to the q_in compare.
   // A failing compare wins over a same-clk acceptance so a late failure of
   // the previous command is never silently dropped.
   always_ff @(posedge clk) begin
      if (Reset) begin
         expect_r <= 8'd0;
         chk1_r   <= 1'b0;
         chk2_r   <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         chk1_r <= 1'b0;
         if (cen && (state_r == S_LOAD)) begin
            expect_r <= P;
            chk1_r   <= 1'b1;
         end else if (cen && (state_r == S_COUNT)) begin
            expect_r <= direction ? (expect_r + 8'd1) : (expect_r - 8'd1);
            chk1_r   <= 1'b1;
         end
         chk2_r <= chk1_r;
         if (chk2_r && (q_in != expect_r)) begin
            mismatch <= 1'b1;
         end else if (accept_s) begin
            mismatch <= 1'b0;
         end
      end
   end
`else
   // q_in has no consumer in this build
   logic unused_q_in_s;
   assign unused_q_in_s = ^q_in;

   // No checker: mismatch is a register held at zero
   always_ff @(posedge clk) begin
      mismatch <= 1'b0;
   end
`endif

endmodule
